// File: rtl/ddr3_init_refresh_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : ddr3_init_refresh_seq_pkg
// Brief  : Command encodings, MR bank codes and FSM states for the DDR3 sequencer.
// Rev    : 1.0
// ============================================================================
package ddr3_init_refresh_seq_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_PREA = 4'b0010;
    localparam logic [3:0] CMD_ZQCL = 4'b0110;

    localparam logic [2:0] BA_MR0 = 3'd0;
    localparam logic [2:0] BA_MR1 = 3'd1;
    localparam logic [2:0] BA_MR2 = 3'd2;
    localparam logic [2:0] BA_MR3 = 3'd3;

    localparam logic [12:0] ADDR_A10 = 13'h0400;

    localparam int         OWED_W      = 4;
    localparam logic [3:0] OWED_MAX    = 4'd9;
    localparam logic [3:0] OWED_URGENT = 4'd8;

    localparam int WAIT_W = 17;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_CKEW = 4'd1,
        ST_XPR  = 4'd2,
        ST_MR2  = 4'd3,
        ST_MR3  = 4'd4,
        ST_MR1  = 4'd5,
        ST_MR0  = 4'd6,
        ST_ZQ   = 4'd7,
        ST_IDLE = 4'd8,
        ST_PRE  = 4'd9,
        ST_REF  = 4'd10
    } seq_state_t;

    // A state entered with this load lasts exactly t cycles.
    function automatic logic [WAIT_W-1:0] wait_load(input int t);
        return WAIT_W'(t - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_init_refresh_seq_timer.sv
`default_nettype none
// ============================================================================
// Module : ddr3_init_refresh_seq_timer
// Brief  : tREFI credit timer with a saturating count of owed refreshes.
// Rev    : 1.0
// ============================================================================
module ddr3_init_refresh_seq_timer
    import ddr3_init_refresh_seq_pkg::*;
#(
    parameter int T_REFI = 1560
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              ref_issued,
    output logic [OWED_W-1:0] owed,
    output logic              req,
    output logic              urgent
);

    localparam int TICK_W = $clog2(T_REFI);

    logic [TICK_W-1:0] tick;
    logic              expire;
    logic [OWED_W-1:0] owed_nx;

    assign expire = en && (tick == '0);

    // A credit landing on the REF cycle cancels out against it.
    always_comb begin
        owed_nx = owed;
        if (expire && !ref_issued) begin
            if (owed != OWED_MAX) owed_nx = owed + 1'b1;
        end else if (ref_issued && !expire) begin
            if (owed != '0) owed_nx = owed - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick   <= TICK_W'(T_REFI - 1);
            owed   <= '0;
            req    <= 1'b0;
            urgent <= 1'b0;
        end else begin
            if (en) tick <= expire ? TICK_W'(T_REFI - 1) : tick - 1'b1;
            owed   <= owed_nx;
            req    <= (owed_nx != '0);
            urgent <= (owed_nx >= OWED_URGENT);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr3_init_refresh_seq.sv
`default_nettype none
// ============================================================================
// Module : ddr3_init_refresh_seq
// Brief  : DDR3 power-up/init sequencer followed by negotiated periodic refresh.
// Rev    : 1.0
// ============================================================================
module ddr3_init_refresh_seq
    import ddr3_init_refresh_seq_pkg::*;
#(
    parameter int          T_RST    = 40000,
    parameter int          T_CKE    = 100000,
    parameter int          T_XPR    = 64,
    parameter int          T_MRD    = 4,
    parameter int          T_MOD    = 12,
    parameter int          T_ZQINIT = 512,
    parameter int          T_RP     = 6,
    parameter int          T_RFC    = 88,
    parameter int          T_REFI   = 1560,
    parameter logic [12:0] MR0_VAL  = 13'h0520,
    parameter logic [12:0] MR1_VAL  = 13'h0044,
    parameter logic [12:0] MR2_VAL  = 13'h0000,
    parameter logic [12:0] MR3_VAL  = 13'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        dram_rst_n,
    output logic        cke,
    output logic [3:0]  cmd_n,
    output logic [2:0]  ba,
    output logic [12:0] addr,
    output logic        seq_own,
    output logic        init_done,
    output logic        ref_req,
    output logic        ref_urgent,
    input  logic        ref_ack
);

    seq_state_t        state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
    logic [3:0]        cmd_nx;
    logic [2:0]        ba_nx;
    logic [12:0]       addr_nx;
    logic              dram_rst_nx, cke_nx, own_nx, done_nx;
    logic              adv, ref_issued;
    logic [OWED_W-1:0] owed;

    // Outputs are computed for the state being entered, so each command
    // appears on the bus for exactly the first cycle of its state.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        cmd_nx      = CMD_NOP;
        ba_nx       = '0;
        addr_nx     = '0;
        dram_rst_nx = dram_rst_n;
        cke_nx      = cke;
        own_nx      = seq_own;
        done_nx     = init_done;
        ref_issued  = 1'b0;

        if (state == ST_IDLE) adv = (owed != '0) && ref_ack;
        else                  adv = (wait_cnt == '0);

        if (wait_cnt != '0) wait_cnt_nx = wait_cnt - 1'b1;

        if (adv) begin
            case (state)
                ST_RST: begin
                    state_nx = ST_CKEW; wait_cnt_nx = wait_load(T_CKE); dram_rst_nx = 1'b1;
                end
                ST_CKEW: begin
                    state_nx = ST_XPR; wait_cnt_nx = wait_load(T_XPR); cke_nx = 1'b1;
                end
                ST_XPR: begin
                    state_nx = ST_MR2; wait_cnt_nx = wait_load(T_MRD);
                    cmd_nx = CMD_MRS; ba_nx = BA_MR2; addr_nx = MR2_VAL;
                end
                ST_MR2: begin
                    state_nx = ST_MR3; wait_cnt_nx = wait_load(T_MRD);
                    cmd_nx = CMD_MRS; ba_nx = BA_MR3; addr_nx = MR3_VAL;
                end
                ST_MR3: begin
                    state_nx = ST_MR1; wait_cnt_nx = wait_load(T_MRD);
                    cmd_nx = CMD_MRS; ba_nx = BA_MR1; addr_nx = MR1_VAL;
                end
                ST_MR1: begin
                    state_nx = ST_MR0; wait_cnt_nx = wait_load(T_MOD);
                    cmd_nx = CMD_MRS; ba_nx = BA_MR0; addr_nx = MR0_VAL;
                end
                ST_MR0: begin
                    state_nx = ST_ZQ; wait_cnt_nx = wait_load(T_ZQINIT);
                    cmd_nx = CMD_ZQCL; addr_nx = ADDR_A10;
                end
                ST_ZQ: begin
                    state_nx = ST_IDLE; done_nx = 1'b1; own_nx = 1'b0;
                end
                ST_IDLE: begin
                    state_nx = ST_PRE; wait_cnt_nx = wait_load(T_RP);
                    own_nx = 1'b1; cmd_nx = CMD_PREA; addr_nx = ADDR_A10;
                end
                ST_PRE: begin
                    state_nx = ST_REF; wait_cnt_nx = wait_load(T_RFC);
                    cmd_nx = CMD_REF; ref_issued = 1'b1;
                end
                ST_REF: begin
                    state_nx = ST_IDLE; own_nx = 1'b0;
                end
                default: begin
                    state_nx = ST_RST; wait_cnt_nx = wait_load(T_RST);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RST;
            wait_cnt   <= wait_load(T_RST);
            dram_rst_n <= 1'b0;
            cke        <= 1'b0;
            cmd_n      <= CMD_NOP;
            ba         <= '0;
            addr       <= '0;
            seq_own    <= 1'b1;
            init_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            wait_cnt   <= wait_cnt_nx;
            dram_rst_n <= dram_rst_nx;
            cke        <= cke_nx;
            cmd_n      <= cmd_nx;
            ba         <= ba_nx;
            addr       <= addr_nx;
            seq_own    <= own_nx;
            init_done  <= done_nx;
        end
    end

    // Enabling on the next-state value starts the first tREFI on the init_done edge.
    ddr3_init_refresh_seq_timer #(
        .T_REFI (T_REFI)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (done_nx),
        .ref_issued (ref_issued),
        .owed       (owed),
        .req        (ref_req),
        .urgent     (ref_urgent)
    );

endmodule
`default_nettype wire

// File: tb/tb_ddr3_init_refresh_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_ddr3_init_refresh_seq
// Brief  : Randomized bench for the DDR3 init/refresh sequencer against a timeline model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ddr3_init_refresh_seq;

    localparam int T_RST = 10, T_CKE = 20, T_XPR = 5, T_MRD = 4, T_MOD = 6;
    localparam int T_ZQINIT = 8, T_RP = 3, T_RFC = 7, T_REFI = 50;
    localparam logic [12:0] MR0_VAL = 13'h0520, MR1_VAL = 13'h0044;
    localparam logic [12:0] MR2_VAL = 13'h0000, MR3_VAL = 13'h0000;

    localparam logic [3:0] NOP = 4'b0111, MRS = 4'b0000, REF = 4'b0001;
    localparam logic [3:0] PREA = 4'b0010, ZQCL = 4'b0110;

    // Absolute init timeline, cycles counted from the first edge after reset release.
    localparam int CKE_AT  = T_RST + T_CKE;
    localparam int MR2_AT  = CKE_AT + T_XPR;
    localparam int MR3_AT  = MR2_AT + T_MRD;
    localparam int MR1_AT  = MR3_AT + T_MRD;
    localparam int MR0_AT  = MR1_AT + T_MRD;
    localparam int ZQ_AT   = MR0_AT + T_MOD;
    localparam int DONE_AT = ZQ_AT + T_ZQINIT;

    logic        clk = 1'b0, rst_n = 1'b0, ref_ack = 1'b0;
    logic        dram_rst_n, cke, seq_own, init_done, ref_req, ref_urgent;
    logic [3:0]  cmd_n;
    logic [2:0]  ba;
    logic [12:0] addr;

    always #5 clk = ~clk;

    ddr3_init_refresh_seq #(
        .T_RST(T_RST), .T_CKE(T_CKE), .T_XPR(T_XPR), .T_MRD(T_MRD), .T_MOD(T_MOD),
        .T_ZQINIT(T_ZQINIT), .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI),
        .MR0_VAL(MR0_VAL), .MR1_VAL(MR1_VAL), .MR2_VAL(MR2_VAL), .MR3_VAL(MR3_VAL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dram_rst_n(dram_rst_n), .cke(cke), .cmd_n(cmd_n),
        .ba(ba), .addr(addr), .seq_own(seq_own), .init_done(init_done),
        .ref_req(ref_req), .ref_urgent(ref_urgent), .ref_ack(ref_ack)
    );

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Timeline model: refresh state is a set of timestamps plus an owed count.
    int cyc, m_owed, next_credit, pre_at, ref_at, free_at, m_refs;

    task automatic model_reset();
        cyc = 0; m_owed = 0; m_refs = 0;
        next_credit = DONE_AT + T_REFI - 1;
        pre_at = -1000; ref_at = -1000; free_at = DONE_AT;
    endtask

    task automatic model_advance(input logic ack_seen);
        int c;
        c = cyc + 1;
        if ((c - 1) >= free_at && m_owed != 0 && ack_seen) begin
            pre_at  = c;
            ref_at  = c + T_RP;
            free_at = ref_at + T_RFC;
        end
        m_owed = m_owed + ((c == next_credit) ? 1 : 0) - ((c == ref_at) ? 1 : 0);
        if (m_owed > 9) m_owed = 9;
        if (c == next_credit) next_credit += T_REFI;
        if (c == ref_at) m_refs++;
        cyc = c;
    endtask

    task automatic compare_all();
        logic [3:0]  ecmd;
        logic [2:0]  eba;
        logic [12:0] eaddr;
        logic        eown;
        ecmd = NOP; eba = 3'd0; eaddr = 13'd0;
        if      (cyc == MR2_AT) begin ecmd = MRS;  eba = 3'd2; eaddr = MR2_VAL; end
        else if (cyc == MR3_AT) begin ecmd = MRS;  eba = 3'd3; eaddr = MR3_VAL; end
        else if (cyc == MR1_AT) begin ecmd = MRS;  eba = 3'd1; eaddr = MR1_VAL; end
        else if (cyc == MR0_AT) begin ecmd = MRS;  eba = 3'd0; eaddr = MR0_VAL; end
        else if (cyc == ZQ_AT)  begin ecmd = ZQCL; eaddr = 13'h0400; end
        else if (cyc == pre_at) begin ecmd = PREA; eaddr = 13'h0400; end
        else if (cyc == ref_at) begin ecmd = REF; end
        eown = (cyc < DONE_AT) || (cyc >= pre_at && cyc < free_at);
        check($sformatf("cmd@%0d", cyc), {cmd_n, ba, addr}, {ecmd, eba, eaddr});
        check($sformatf("pins@%0d", cyc), {dram_rst_n, cke}, {cyc >= T_RST, cyc >= CKE_AT});
        check($sformatf("flags@%0d", cyc), {seq_own, init_done, ref_req, ref_urgent},
              {eown, cyc >= DONE_AT, m_owed != 0, m_owed >= 8});
        if (!seq_own) check($sformatf("nop_free@%0d", cyc), cmd_n, NOP);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_advance(ref_ack);
        compare_all();
    endtask

    task automatic check_reset(input string tag);
        check(tag, {dram_rst_n, cke, cmd_n, ba, addr, seq_own, init_done, ref_req, ref_urgent},
              {1'b0, 1'b0, NOP, 3'd0, 13'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_pre, budget, drain_refs_model;
        rst_n = 1'b0; ref_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        release_reset();

        // Init with ack noise; ack is meaningless until refresh is owed.
        for (int i = 0; i < DONE_AT + 2; i++) begin
            step();
            ref_ack = 1'($urandom_range(0, 1));
        end

        ref_ack = 1'b1;
        first_pre = -1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (cmd_n == PREA && first_pre < 0) first_pre = cyc;
        end
        check("first_prea_cycle", first_pre, DONE_AT + T_REFI);

        for (int i = 0; i < 600; i++) begin
            ref_ack = ($urandom_range(0, 3) != 0);
            step();
        end

        // Starve the sequencer long enough to saturate the owed count.
        ref_ack = 1'b0;
        for (int i = 0; i < 9 * T_REFI + 5; i++) step();
        check("sat_urgent", ref_urgent, 1'b1);
        check("sat_req", ref_req, 1'b1);

        drain_refs_model = m_refs;
        ref_ack = 1'b1;
        budget = 0;
        begin
            int seen;
            seen = 0;
            while (budget < 300 && !(ref_req == 1'b0 && seq_own == 1'b0)) begin
                step();
                if (cmd_n == REF) seen++;
                budget++;
            end
            check("drain_done", budget < 300, 1'b1);
            check("drain_refs", seen, m_refs - drain_refs_model);
            check("drain_at_least_9", seen >= 9, 1'b1);
        end

        // Line the REF cycle up with a credit while exactly one refresh is owed.
        ref_ack = 1'b0;
        budget = 0;
        while (budget < 200 && m_owed != 1) begin step(); budget++; end
        check("coinc_setup", m_owed, 1);
        budget = 0;
        while (budget < 200 && cyc != next_credit - T_RP - 1) begin step(); budget++; end
        ref_ack = 1'b1;
        for (int i = 0; i < T_RP + 1; i++) step();
        check("coinc_cmd", cmd_n, REF);
        check("coinc_req", ref_req, 1'b1);
        // Drop ack inside tRFC; the sequence must still finish.
        ref_ack = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("rfc_still_own", seq_own, 1'b1);
        ref_ack = 1'b1;
        first_pre = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (cmd_n == PREA && first_pre < 0) first_pre = cyc;
        end
        check("second_refresh", first_pre >= 0, 1'b1);

        // Asynchronous reset in the middle of normal operation.
        for (int i = 0; i < 7; i++) begin ref_ack = 1'($urandom_range(0, 1)); step(); end
        #2 rst_n = 1'b0;
        #1 check_reset("async_rst_op");
        release_reset();
        while (cyc < MR1_AT) step();
        check("mr1_cmd", cmd_n, MRS);
        #2 rst_n = 1'b0;
        #1 check_reset("async_rst_mr1");
        release_reset();

        for (int i = 0; i < DONE_AT + 400; i++) begin
            ref_ack = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
